// File: rtl/wm_phase_timer.sv
// rtl/wm_phase_timer.sv - phase timer and program scheduler for the washing-machine controller
// Infers wash/rinse/spin from actuator outputs and produces per-program phase timeouts.
module wm_phase_timer #(
  parameter int PRESCALE = 1000,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       prog_sel,
  input  logic             prog_load,
  input  logic             pause,
  input  logic             door_lock,
  input  logic             motor_on,
  input  logic             soap_wash,
  input  logic             water_wash,
  input  logic             drain_value_on,
  output logic             cycle_timeout,
  output logic             spin_timeout,
  output logic [CNT_W-1:0] time_left,
  output logic [1:0]       phase,
  output logic             prog_err,
  output logic             abort
);

  localparam int PS_W = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, WASH = 2'd1, RINSE = 2'd2, SPIN = 2'd3} phase_t;

  phase_t          state;
  phase_t          want;
  logic [1:0]      prog;
  logic [PS_W-1:0] prescale;
  logic            q_wash, q_rinse, q_spin, cur_q;

  assign q_wash  = door_lock & motor_on & soap_wash  & ~drain_value_on;
  assign q_rinse = door_lock & motor_on & water_wash & ~drain_value_on;
  assign q_spin  = door_lock & motor_on & drain_value_on;
  assign phase   = state;

  // Spin excludes wash/rinse by construction; wash wins if soap and water are both on.
  always_comb begin
    want = IDLE;
    if (q_spin)       want = SPIN;
    else if (q_wash)  want = WASH;
    else if (q_rinse) want = RINSE;
  end

  always_comb begin
    cur_q = 1'b0;
    case (state)
      WASH:    cur_q = q_wash;
      RINSE:   cur_q = q_rinse;
      SPIN:    cur_q = q_spin;
      default: cur_q = 1'b0;
    endcase
  end

  function automatic logic [CNT_W-1:0] phase_len(input logic [1:0] p, input phase_t ph);
    int n;
    n = 0;
    case (ph)
      WASH:    n = (p == 2'd0) ? 4 : (p == 2'd2) ? 12 : 8;
      RINSE:   n = (p == 2'd0) ? 2 : (p == 2'd2) ? 12 : 8;
      SPIN:    n = (p == 2'd0) ? 3 : (p == 2'd2) ? 8  : 6;
      default: n = 0;
    endcase
    return CNT_W'(n);
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      prog          <= 2'd1;
      prescale      <= '0;
      time_left     <= '0;
      cycle_timeout <= 1'b0;
      spin_timeout  <= 1'b0;
      prog_err      <= 1'b0;
      abort         <= 1'b0;
    end else begin
      prog_err <= 1'b0;
      abort    <= 1'b0;

      // An entry happening on this edge makes the machine busy already.
      if (prog_load) begin
        if (prog_sel == 2'd3 || state != IDLE || want != IDLE) prog_err <= 1'b1;
        else                                                   prog     <= prog_sel;
      end

      if (state != IDLE && !door_lock) begin
        state         <= IDLE;
        prescale      <= '0;
        time_left     <= '0;
        cycle_timeout <= 1'b0;
        spin_timeout  <= 1'b0;
        abort         <= 1'b1;
      end else if (state == IDLE || !cur_q) begin
        state         <= want;
        prescale      <= '0;
        time_left     <= phase_len(prog, want);
        cycle_timeout <= 1'b0;
        spin_timeout  <= 1'b0;
      end else begin
        if (!pause) begin
          if (prescale == PS_W'(PRESCALE - 1)) begin
            prescale <= '0;
            if (time_left != '0) time_left <= time_left - 1'b1;
          end else begin
            prescale <= prescale + 1'b1;
          end
        end
        if (time_left == '0) begin
          if (state == SPIN) spin_timeout  <= 1'b1;
          else               cycle_timeout <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_wm_phase_timer.sv
// tb/tb_wm_phase_timer.sv - self-checking bench for wm_phase_timer
// Directed scenarios plus randomized traffic against a tick-count reference model.
module tb_wm_phase_timer;

  localparam int PRESCALE = 4;
  localparam int CNT_W    = 8;

  logic             clk = 1'b0;
  logic             reset, prog_load, pause;
  logic [1:0]       prog_sel;
  logic             door_lock, motor_on, soap_wash, water_wash, drain_value_on;
  logic             cycle_timeout, spin_timeout, prog_err, abort;
  logic [CNT_W-1:0] time_left;
  logic [1:0]       phase;

  int checks = 0;
  int errors = 0;

  // Reference model state: run counts unpaused in-phase clocks since entry.
  int m_ph, m_prog, m_len, m_run, m_tl, m_ct, m_st, m_err, m_abort;

  wm_phase_timer #(.PRESCALE(PRESCALE), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .prog_sel(prog_sel), .prog_load(prog_load), .pause(pause),
    .door_lock(door_lock), .motor_on(motor_on), .soap_wash(soap_wash),
    .water_wash(water_wash), .drain_value_on(drain_value_on),
    .cycle_timeout(cycle_timeout), .spin_timeout(spin_timeout), .time_left(time_left),
    .phase(phase), .prog_err(prog_err), .abort(abort)
  );

  always #5 clk = ~clk;

  function automatic int table_len(input int p, input int ph);
    int t [3][4] = '{'{0, 4, 2, 3}, '{0, 8, 8, 6}, '{0, 12, 12, 8}};
    return t[p][ph];
  endfunction

  function automatic bit qual(input int ph);
    bit base;
    base = door_lock && motor_on;
    case (ph)
      1:       return base && soap_wash && !drain_value_on;
      2:       return base && water_wash && !drain_value_on;
      3:       return base && drain_value_on;
      default: return 1'b0;
    endcase
  endfunction

  function automatic void model_update();
    int want, old_tl, old_prog;
    want = qual(3) ? 3 : qual(1) ? 1 : qual(2) ? 2 : 0;
    if (reset) begin
      m_ph = 0; m_prog = 1; m_len = 0; m_run = 0; m_tl = 0;
      m_ct = 0; m_st = 0; m_err = 0; m_abort = 0;
      return;
    end
    m_err = 0; m_abort = 0;
    old_prog = m_prog;
    if (prog_load) begin
      if (prog_sel == 2'd3 || m_ph != 0 || want != 0) m_err = 1;
      else m_prog = int'(prog_sel);
    end
    if (m_ph != 0 && !door_lock) begin
      m_ph = 0; m_tl = 0; m_run = 0; m_ct = 0; m_st = 0; m_abort = 1;
    end else if (m_ph == 0 || !qual(m_ph)) begin
      m_ph = want; m_run = 0; m_ct = 0; m_st = 0;
      m_len = (want == 0) ? 0 : table_len(old_prog, want);
      m_tl = m_len;
    end else begin
      old_tl = m_tl;
      if (!pause) m_run++;
      m_tl = m_len - m_run / PRESCALE;
      if (m_tl < 0) m_tl = 0;
      if (old_tl == 0) begin
        if (m_ph == 3) m_st = 1;
        else m_ct = 1;
      end
    end
  endfunction

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic set_act(input bit d, input bit m, input bit s, input bit w, input bit dr);
    door_lock = d; motor_on = m; soap_wash = s; water_wash = w; drain_value_on = dr;
  endtask

  task automatic load(input logic [1:0] sel);
    prog_sel = sel; prog_load = 1'b1;
    step();
    prog_load = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; prog_load = 1'b0; prog_sel = 2'd0; pause = 1'b0;
    set_act(0, 0, 0, 0, 0);
    step(); step();
    reset = 1'b0;
    checks++;
    if ({cycle_timeout, spin_timeout, time_left, phase, prog_err, abort} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got ct=%0b st=%0b tl=%0d ph=%0d err=%0b ab=%0b required all 0",
               cycle_timeout, spin_timeout, time_left, phase, prog_err, abort);
    end
  endtask

  task automatic test_quick_wash();
    int first;
    load(2'd0);
    set_act(1, 1, 1, 0, 0);
    step();
    checks++;
    if (phase !== 2'd1 || time_left !== 8'd4) begin
      errors++;
      $display("FAIL quick_entry: phase=%0d tl=%0d required 1/4", phase, time_left);
    end
    first = -1;
    for (int k = 1; k <= 40 && first < 0; k++) begin
      step();
      if (k <= 16) begin
        checks++;
        if (time_left !== CNT_W'(4 - k / 4) || cycle_timeout !== 1'b0) begin
          errors++;
          $display("FAIL quick_tl k=%0d: tl=%0d ct=%0b required %0d/0", k, time_left, cycle_timeout, 4 - k / 4);
        end
      end
      if (cycle_timeout) first = k;
    end
    checks++;
    if (first !== 17) begin
      errors++;
      $display("FAIL quick_latency: got %0d required 17", first);
    end
    set_act(0, 0, 0, 0, 0);
    step();
  endtask

  task automatic test_normal_rinse();
    int first;
    load(2'd1);
    set_act(1, 1, 0, 1, 0);
    step();
    first = -1;
    for (int k = 1; k <= 60 && first < 0; k++) begin
      step();
      if (cycle_timeout) first = k;
    end
    checks++;
    if (first !== 33) begin
      errors++;
      $display("FAIL rinse_latency: got %0d required 33", first);
    end
    motor_on = 1'b0;
    step();
    checks++;
    if (cycle_timeout !== 1'b0 || phase !== 2'd0) begin
      errors++;
      $display("FAIL rinse_exit: ct=%0b phase=%0d required 0/0", cycle_timeout, phase);
    end
  endtask

  task automatic test_heavy_spin_pause();
    int first;
    logic [CNT_W-1:0] frozen;
    load(2'd2);
    set_act(1, 1, 0, 0, 1);
    step();
    first = -1;
    frozen = '0;
    for (int k = 1; k <= 80 && first < 0; k++) begin
      step();
      if (k == 10) begin pause = 1'b1; frozen = time_left; end
      if (k == 20) pause = 1'b0;
      if (k > 10 && k <= 20) begin
        checks++;
        if (time_left !== frozen) begin
          errors++;
          $display("FAIL spin_pause_freeze k=%0d: tl=%0d required %0d", k, time_left, frozen);
        end
      end
      if (spin_timeout) first = k;
    end
    checks++;
    if (first !== 43 || cycle_timeout !== 1'b0) begin
      errors++;
      $display("FAIL spin_latency: got %0d ct=%0b required 43/0", first, cycle_timeout);
    end
    set_act(0, 0, 0, 0, 0);
    step();
  endtask

  task automatic test_door_abort();
    bool_wait: begin
      int n;
      set_act(1, 1, 1, 0, 0);
      n = 0;
      step();
      while (time_left !== 8'd3 && n < 100) begin step(); n++; end
      checks++;
      if (n >= 100) begin
        errors++;
        $display("FAIL door_wait: tl=%0d required 3 within 100 clks", time_left);
      end
    end
    door_lock = 1'b0;
    step();
    checks++;
    if (abort !== 1'b1 || phase !== 2'd0 || time_left !== '0 || cycle_timeout !== 1'b0) begin
      errors++;
      $display("FAIL door_abort: ab=%0b ph=%0d tl=%0d ct=%0b required 1/0/0/0", abort, phase, time_left, cycle_timeout);
    end
    step();
    checks++;
    if (abort !== 1'b0 || cycle_timeout !== 1'b0) begin
      errors++;
      $display("FAIL door_abort_pulse: ab=%0b ct=%0b required 0/0", abort, cycle_timeout);
    end
    set_act(0, 0, 0, 0, 0);
  endtask

  task automatic test_prog_err();
    int first;
    do_reset();
    load(2'd3);
    checks++;
    if (prog_err !== 1'b1) begin
      errors++;
      $display("FAIL err_reserved: prog_err=%0b required 1", prog_err);
    end
    step();
    checks++;
    if (prog_err !== 1'b0) begin
      errors++;
      $display("FAIL err_pulse: prog_err=%0b required 0", prog_err);
    end
    // Load on the entry edge counts as busy.
    set_act(1, 1, 1, 0, 0);
    load(2'd0);
    checks++;
    if (prog_err !== 1'b1 || time_left !== 8'd8) begin
      errors++;
      $display("FAIL err_entry: prog_err=%0b tl=%0d required 1/8", prog_err, time_left);
    end
    step();
    load(2'd2);
    checks++;
    if (prog_err !== 1'b1) begin
      errors++;
      $display("FAIL err_busy: prog_err=%0b required 1", prog_err);
    end
    first = -1;
    for (int k = 3; k <= 60 && first < 0; k++) begin
      step();
      if (cycle_timeout) first = k;
    end
    checks++;
    if (first !== 33) begin
      errors++;
      $display("FAIL err_length: timeout at %0d required 33", first);
    end
    set_act(0, 0, 0, 0, 0);
    step();
  endtask

  task automatic test_reset_mid_spin();
    int n;
    load(2'd0);
    set_act(1, 1, 0, 0, 1);
    n = 0;
    step();
    while (spin_timeout !== 1'b1 && n < 50) begin step(); n++; end
    checks++;
    if (spin_timeout !== 1'b1) begin
      errors++;
      $display("FAIL rst_spin_wait: spin_timeout=%0b required 1", spin_timeout);
    end
    reset = 1'b1;
    step();
    checks++;
    if ({cycle_timeout, spin_timeout, time_left, phase, prog_err, abort} !== '0) begin
      errors++;
      $display("FAIL rst_mid_spin: st=%0b tl=%0d ph=%0d required 0/0/0", spin_timeout, time_left, phase);
    end
    set_act(0, 0, 0, 0, 0);
    step();
    reset = 1'b0;
    set_act(1, 1, 1, 0, 0);
    step();
    checks++;
    if (phase !== 2'd1 || time_left !== 8'd8) begin
      errors++;
      $display("FAIL rst_prog_normal: phase=%0d tl=%0d required 1/8", phase, time_left);
    end
    set_act(0, 0, 0, 0, 0);
    step();
  endtask

  task automatic test_random();
    logic [CNT_W+6:0] got, exp;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 15) == 0) begin
        case ($urandom_range(0, 5))
          0: set_act(0, 0, 0, 0, 0);
          1: set_act(1, 1, 1, 0, 0);
          2: set_act(1, 1, 0, 1, 0);
          3: set_act(1, 1, 0, 0, 1);
          4: set_act(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
          default: set_act(0, 1, 1, 0, 0);
        endcase
      end
      if ($urandom_range(0, 7) == 0) pause = ~pause;
      prog_load = ($urandom_range(0, 19) == 0);
      prog_sel  = 2'($urandom_range(0, 3));
      reset     = ($urandom_range(0, 499) == 0);
      step();
      got = {cycle_timeout, spin_timeout, time_left, phase, prog_err, abort};
      exp = {1'(m_ct), 1'(m_st), CNT_W'(m_tl), 2'(m_ph), 1'(m_err), 1'(m_abort)};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL random cyc=%0d: ct/st/tl/ph/err/ab got %0b/%0b/%0d/%0d/%0b/%0b required %0d/%0d/%0d/%0d/%0d/%0d",
                 i, cycle_timeout, spin_timeout, time_left, phase, prog_err, abort,
                 m_ct, m_st, m_tl, m_ph, m_err, m_abort);
      end
    end
    reset = 1'b0; prog_load = 1'b0; pause = 1'b0;
  endtask

  initial begin
    test_reset();
    test_quick_wash();
    test_normal_rinse();
    test_heavy_spin_pause();
    test_door_abort();
    test_prog_err();
    test_reset_mid_spin();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
